// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI-lite initiator: local cmd/rsp handshake in, one AW+W/B or AR/R transaction out.
// Optional watchdog on the response phase is built when AXIL_MST_TIMEOUT_EN is defined.
module axi_lite_cmd_master #(
   parameter int DATA_SIZE      = 32,
   parameter int ADDR_SIZE      = 32,
   parameter int ID_SIZE        = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   cmd_valid_i,
   output logic                   cmd_ready_o,
   input  logic                   cmd_write_i,
   input  logic [ADDR_SIZE-1:0]   cmd_addr_i,
   input  logic [DATA_SIZE-1:0]   cmd_wdata_i,
   input  logic [ID_SIZE-1:0]     cmd_id_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic                   rsp_write_o,
   output logic [DATA_SIZE-1:0]   rsp_rdata_o,
   output logic [1:0]             rsp_resp_o,
   output logic [ID_SIZE-1:0]     rsp_id_o,
   output logic                   rsp_timeout_o,
   output logic                   awvalid_o,
   input  logic                   awready_i,
   output logic [ADDR_SIZE-1:0]   awaddr_o,
   output logic [ID_SIZE-1:0]     awid_o,
   output logic                   wvalid_o,
   input  logic                   wready_i,
   output logic [DATA_SIZE-1:0]   wdata_o,
   output logic [DATA_SIZE/8-1:0] wstrb_o,
   input  logic                   bvalid_i,
   output logic                   bready_o,
   input  logic [1:0]             bresp_i,
   input  logic [ID_SIZE-1:0]     bid_i,
   output logic                   arvalid_o,
   input  logic                   arready_i,
   output logic [ADDR_SIZE-1:0]   araddr_o,
   output logic [ID_SIZE-1:0]     arid_o,
   input  logic                   rvalid_i,
   output logic                   rready_o,
   input  logic [DATA_SIZE-1:0]   rdata_i,
   input  logic [1:0]             rresp_i,
   input  logic [ID_SIZE-1:0]     rid_i
);

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_e;

`ifdef AXIL_MST_TIMEOUT_EN
   localparam logic IDLE_ABSORB = 1'b1;
   localparam int   CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             write_q, write_d;
   logic             rsp_timeout_q, rsp_timeout_d;
`else
   localparam logic IDLE_ABSORB = 1'b0;
`endif

   state_e                 state_q, state_d;
   logic                   cmd_ready_q, cmd_ready_d;
   logic                   awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
   logic                   bready_q, bready_d, rready_q, rready_d;
   logic [ADDR_SIZE-1:0]   addr_q, addr_d;
   logic [DATA_SIZE-1:0]   wdata_q, wdata_d;
   logic [ID_SIZE-1:0]     id_q, id_d;
   logic                   rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
   logic [DATA_SIZE-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [1:0]             rsp_resp_q, rsp_resp_d;
   logic [ID_SIZE-1:0]     rsp_id_q, rsp_id_d;

   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      arvalid_d   = arvalid_q;
      bready_d    = bready_q;
      rready_d    = rready_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      id_d        = id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;
      rsp_id_d    = rsp_id_q;
`ifdef AXIL_MST_TIMEOUT_EN
      cnt_d         = cnt_q;
      write_d       = write_q;
      rsp_timeout_d = rsp_timeout_q;
`endif
      case (state_q)
         IDLE: begin
            cmd_ready_d = 1'b1;
            bready_d    = IDLE_ABSORB;
            rready_d    = IDLE_ABSORB;
            if (cmd_valid_i && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               bready_d    = 1'b0;
               rready_d    = 1'b0;
               addr_d      = cmd_addr_i;
               wdata_d     = cmd_wdata_i;
               id_d        = cmd_id_i;
`ifdef AXIL_MST_TIMEOUT_EN
               write_d     = cmd_write_i;
`endif
               if (cmd_write_i) begin
                  state_d   = WR_REQ;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = RD_REQ;
                  arvalid_d = 1'b1;
               end
            end
         end
         WR_REQ: begin
            // AW and W complete independently; a channel already done counts as done
            if (awready_i) awvalid_d = 1'b0;
            if (wready_i)  wvalid_d  = 1'b0;
            if ((!awvalid_q || awready_i) && (!wvalid_q || wready_i)) begin
               state_d  = WR_RESP;
               bready_d = 1'b1;
            end
         end
         WR_RESP: begin
            if (bvalid_i) begin
               state_d     = RSP;
               bready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_write_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_resp_d  = bresp_i;
               rsp_id_d    = bid_i;
            end
         end
         RD_REQ: begin
            if (arready_i) begin
               state_d   = RD_RESP;
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
            end
         end
         RD_RESP: begin
            if (rvalid_i) begin
               state_d     = RSP;
               rready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_write_d = 1'b0;
               rsp_rdata_d = rdata_i;
               rsp_resp_d  = rresp_i;
               rsp_id_d    = rid_i;
            end
         end
         RSP: begin
            if (rsp_ready_i) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               bready_d    = IDLE_ABSORB;
               rready_d    = IDLE_ABSORB;
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef AXIL_MST_TIMEOUT_EN
      if (state_q == IDLE) begin
         cnt_d         = '0;
         rsp_timeout_d = 1'b0;
      end else if (state_q != RSP) begin
         cnt_d = cnt_q + 1'b1;
         // A real response in the expiry cycle still wins over the watchdog
         if (cnt_q == CNT_LAST && state_d != RSP) begin
            state_d       = RSP;
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            arvalid_d     = 1'b0;
            bready_d      = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_write_d   = write_q;
            rsp_rdata_d   = '0;
            rsp_resp_d    = 2'b11;
            rsp_id_d      = id_q;
            rsp_timeout_d = 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         bready_q    <= 1'b0;
         rready_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         id_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
         rsp_id_q    <= '0;
`ifdef AXIL_MST_TIMEOUT_EN
         cnt_q         <= '0;
         write_q       <= 1'b0;
         rsp_timeout_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         arvalid_q   <= arvalid_d;
         bready_q    <= bready_d;
         rready_q    <= rready_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
         rsp_id_q    <= rsp_id_d;
`ifdef AXIL_MST_TIMEOUT_EN
         cnt_q         <= cnt_d;
         write_q       <= write_d;
         rsp_timeout_q <= rsp_timeout_d;
`endif
      end
   end

   assign cmd_ready_o = cmd_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_write_o = rsp_write_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_resp_o  = rsp_resp_q;
   assign rsp_id_o    = rsp_id_q;
`ifdef AXIL_MST_TIMEOUT_EN
   assign rsp_timeout_o = rsp_timeout_q;
`else
   assign rsp_timeout_o = 1'b0;
`endif
   assign awvalid_o = awvalid_q;
   assign awaddr_o  = addr_q;
   assign awid_o    = id_q;
   assign wvalid_o  = wvalid_q;
   assign wdata_o   = wdata_q;
   // Full-word strobes, held low outside a W beat so every output idles at zero
   assign wstrb_o   = {(DATA_SIZE/8){wvalid_q}};
   assign bready_o  = bready_q;
   assign arvalid_o = arvalid_q;
   assign araddr_o  = addr_q;
   assign arid_o    = id_q;
   assign rready_o  = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Scoreboard bench for axi_lite_cmd_master: directed commands against a behavioural AXI-lite slave.
// Build with AXIL_MST_TIMEOUT_EN defined to also exercise the watchdog.
module tb_axi_lite_cmd_master;
   localparam int TO = 40;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, cmd_valid, cmd_ready_o, cmd_write, rsp_valid_o, rsp_ready;
   logic [31:0] cmd_addr, cmd_wdata, rsp_rdata_o;
   logic [3:0]  cmd_id, rsp_id_o;
   logic [1:0]  rsp_resp_o;
   logic        rsp_write_o, rsp_timeout_o;
   logic        awvalid_o, awready, wvalid_o, wready, bvalid, bready_o;
   logic        arvalid_o, arready, rvalid, rready_o;
   logic [31:0] awaddr_o, wdata_o, araddr_o, rdata;
   logic [3:0]  awid_o, arid_o, bid, rid, wstrb_o;
   logic [1:0]  bresp, rresp;

   axi_lite_cmd_master #(.DATA_SIZE(32), .ADDR_SIZE(32), .ID_SIZE(4), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk), .reset_n_i(reset_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write),
      .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_id_i(cmd_id),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_write_o(rsp_write_o),
      .rsp_rdata_o(rsp_rdata_o), .rsp_resp_o(rsp_resp_o), .rsp_id_o(rsp_id_o),
      .rsp_timeout_o(rsp_timeout_o),
      .awvalid_o(awvalid_o), .awready_i(awready), .awaddr_o(awaddr_o), .awid_o(awid_o),
      .wvalid_o(wvalid_o), .wready_i(wready), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
      .bvalid_i(bvalid), .bready_o(bready_o), .bresp_i(bresp), .bid_i(bid),
      .arvalid_o(arvalid_o), .arready_i(arready), .araddr_o(araddr_o), .arid_o(arid_o),
      .rvalid_i(rvalid), .rready_o(rready_o), .rdata_i(rdata), .rresp_i(rresp), .rid_i(rid)
   );

   typedef struct {
      logic        wr;
      logic [31:0] rdata;
      logic [1:0]  resp;
      logic [3:0]  id;
      logic        to;
   } rsp_t;

   rsp_t        exp_rsp[$];
   logic [35:0] exp_aw[$];
   logic [31:0] exp_w[$];
   logic [35:0] exp_ar[$];

   int  n_chk = 0, n_fail = 0, rsp_cnt = 0, aw_hi = 0;
   time hs_time = 0, rsp_first_time = 0;
   int  aw_stall_cfg = 0, w_stall_cfg = 0;
   bit  b_mute = 1'b0;
   logic [31:0] mem [logic [31:0]];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: required event did not occur or was not expected", name);
   endtask

   function automatic logic outs_zero();
      return ~|{cmd_ready_o, rsp_valid_o, rsp_write_o, rsp_rdata_o, rsp_resp_o, rsp_id_o,
                rsp_timeout_o, awvalid_o, awaddr_o, awid_o, wvalid_o, wdata_o, wstrb_o,
                bready_o, arvalid_o, araddr_o, arid_o, rready_o};
   endfunction

   // Behavioural slave: checks request beats against the scoreboard, answers one cycle later
   logic        aw_got = 0, w_got = 0, ar_got = 0, aw_seen = 0, w_seen = 0;
   logic [31:0] aw_a, w_d, ar_a;
   logic [3:0]  aw_i, ar_i;
   int          aw_left = 0, w_left = 0;
   initial begin
      logic [35:0] e;
      logic [31:0] ew;
      bit b_hs, r_hs;
      awready = 1; wready = 1; arready = 1; bvalid = 0; rvalid = 0;
      bresp = 0; bid = 0; rresp = 0; rid = 0; rdata = 0;
      forever begin
         @(posedge clk);
         b_hs = bvalid && bready_o;
         r_hs = rvalid && rready_o;
         if (reset_n) begin
            if (awvalid_o) aw_hi++;
            if (awvalid_o && awready) begin
               aw_got = 1; aw_a = awaddr_o; aw_i = awid_o;
               if (exp_aw.size() == 0) fail_now("aw_unexpected_beat");
               else begin
                  e = exp_aw.pop_front();
                  chk("awaddr", awaddr_o, e[31:0]);
                  chk("awid", awid_o, e[35:32]);
               end
            end
            if (wvalid_o && wready) begin
               w_got = 1; w_d = wdata_o;
               if (exp_w.size() == 0) fail_now("w_unexpected_beat");
               else begin
                  ew = exp_w.pop_front();
                  chk("wdata", wdata_o, ew);
                  chk("wstrb", wstrb_o, 4'hF);
               end
            end
            if (arvalid_o && arready) begin
               ar_got = 1; ar_a = araddr_o; ar_i = arid_o;
               if (exp_ar.size() == 0) fail_now("ar_unexpected_beat");
               else begin
                  e = exp_ar.pop_front();
                  chk("araddr", araddr_o, e[31:0]);
                  chk("arid", arid_o, e[35:32]);
               end
            end
         end
         #1;
         if (!reset_n) begin
            aw_got = 0; w_got = 0; ar_got = 0; bvalid = 0; rvalid = 0;
         end else begin
            if (b_hs) bvalid = 0;
            if (r_hs) rvalid = 0;
            if (aw_got && w_got && !bvalid && !b_mute) begin
               if (aw_a >= 32'h1000) begin mem[aw_a] = w_d; bresp = 2'b00; end
               else bresp = 2'b10;
               bid = aw_i; bvalid = 1; aw_got = 0; w_got = 0;
            end
            if (ar_got && !rvalid) begin
               if (ar_a >= 32'h1000) begin
                  rdata = mem.exists(ar_a) ? mem[ar_a] : 32'h0; rresp = 2'b00;
               end else begin
                  rdata = 32'h0; rresp = 2'b10;
               end
               rid = ar_i; rvalid = 1; ar_got = 0;
            end
         end
         if (awvalid_o) begin
            if (!aw_seen) begin aw_left = aw_stall_cfg; aw_seen = 1; end
            awready = (aw_left == 0);
            if (aw_left > 0) aw_left--;
         end else begin aw_seen = 0; awready = 1; end
         if (wvalid_o) begin
            if (!w_seen) begin w_left = w_stall_cfg; w_seen = 1; end
            wready = (w_left == 0);
            if (w_left > 0) w_left--;
         end else begin w_seen = 0; wready = 1; end
      end
   end

   // Completion monitor
   initial begin
      rsp_t e;
      logic prev = 0;
      forever begin
         @(posedge clk);
         if (rsp_valid_o && !prev) rsp_first_time = $time;
         prev = rsp_valid_o;
         if (reset_n && rsp_valid_o && rsp_ready) begin
            $display("rsp #%0d: write=%0b id=%0h resp=%0b rdata=%08h timeout=%0b",
                     rsp_cnt, rsp_write_o, rsp_id_o, rsp_resp_o, rsp_rdata_o, rsp_timeout_o);
            if (exp_rsp.size() == 0) fail_now("rsp_unexpected");
            else begin
               e = exp_rsp.pop_front();
               chk("rsp_write", rsp_write_o, e.wr);
               chk("rsp_rdata", rsp_rdata_o, e.rdata);
               chk("rsp_resp", rsp_resp_o, e.resp);
               chk("rsp_id", rsp_id_o, e.id);
               chk("rsp_timeout", rsp_timeout_o, e.to);
            end
            rsp_cnt++;
         end
      end
   end

   task automatic wait_rsp(input int base);
      bit got = 0;
      for (int i = 0; i < 2000 && !got; i++) begin
         @(posedge clk);
         if (rsp_cnt > base) got = 1;
      end
      #1;
      if (!got) fail_now("rsp_wait_timeout");
   endtask

   // mode 0: expect completion and wait; 1: expect completion, do not wait; 2: no completion
   task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] id, input logic [1:0] eresp, input logic [31:0] erdata,
                         input logic eto, input int mode);
      rsp_t e;
      int   base;
      bit   got = 0;
      if (wr) begin exp_aw.push_back({id, addr}); exp_w.push_back(data); end
      else exp_ar.push_back({id, addr});
      if (mode != 2) begin
         e.wr = wr; e.rdata = erdata; e.resp = eresp; e.id = id; e.to = eto;
         exp_rsp.push_back(e);
      end
      base = rsp_cnt;
      cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_id = id; cmd_valid = 1;
      for (int i = 0; i < 200 && !got; i++) begin
         @(posedge clk);
         if (cmd_ready_o) begin got = 1; hs_time = $time; end
      end
      #1 cmd_valid = 0;
      if (!got) fail_now("cmd_accept_timeout");
      if (mode == 0) wait_rsp(base);
   endtask

   initial begin
      logic [39:0] snap;
      int base, awb;
      bit got;
      reset_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_id = 0;
      rsp_ready = 1;
      repeat (3) @(posedge clk);
      #1 chk("reset_outputs_zero", outs_zero(), 1'b1);
      reset_n = 1;
      repeat (2) @(posedge clk);
      #1 chk("cmd_ready_after_reset", cmd_ready_o, 1'b1);

      // 1: write, all readies high, three-cycle latency
      do_cmd(1, 32'h3005, 32'hDEADBEEF, 4'h3, 2'b00, 32'h0, 1'b0, 0);
      chk("write_latency", (rsp_first_time - hs_time) / 10, 3);
      // 2: read back
      do_cmd(0, 32'h3005, 32'h0, 4'h5, 2'b00, 32'hDEADBEEF, 1'b0, 0);
      chk("read_latency", (rsp_first_time - hs_time) / 10, 3);
      // 3: awready delayed four cycles, W completes first
      aw_stall_cfg = 4; awb = aw_hi;
      do_cmd(1, 32'h3010, 32'h12345678, 4'h7, 2'b00, 32'h0, 1'b0, 0);
      chk("awvalid_held_cycles", aw_hi - awb, 5);
      aw_stall_cfg = 0;
      // wready delayed, AW completes first
      w_stall_cfg = 2;
      do_cmd(1, 32'h3020, 32'hA5A5_0F0F, 4'hF, 2'b00, 32'h0, 1'b0, 0);
      w_stall_cfg = 0;
      // 4: unmapped read and write
      do_cmd(0, 32'h0010, 32'h0, 4'h2, 2'b10, 32'h0, 1'b0, 0);
      do_cmd(1, 32'h0020, 32'h1111_2222, 4'h1, 2'b10, 32'h0, 1'b0, 0);
      // 5: completion back-pressured for six cycles
      rsp_ready = 0;
      do_cmd(0, 32'h3010, 32'h0, 4'h9, 2'b00, 32'h12345678, 1'b0, 1);
      got = 0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(posedge clk);
         if (rsp_valid_o) got = 1;
      end
      #1;
      if (!got) fail_now("held_rsp_valid");
      snap = {rsp_write_o, rsp_rdata_o, rsp_resp_o, rsp_id_o, rsp_timeout_o};
      repeat (6) begin
         @(posedge clk); #1;
         chk("held_rsp_stable", {rsp_valid_o, rsp_write_o, rsp_rdata_o, rsp_resp_o, rsp_id_o, rsp_timeout_o}, {1'b1, snap});
         chk("held_cmd_ready", cmd_ready_o, 1'b0);
         chk("held_no_request", {awvalid_o, arvalid_o}, 2'b00);
      end
      base = rsp_cnt;
      rsp_ready = 1;
      wait_rsp(base);
      do_cmd(0, 32'h3020, 32'h0, 4'hC, 2'b00, 32'hA5A5_0F0F, 1'b0, 0);
      // 6: reset while waiting for B
      b_mute = 1;
      do_cmd(1, 32'h3030, 32'h5555_AAAA, 4'h6, 2'b00, 32'h0, 1'b0, 2);
      got = 0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(posedge clk);
         if (bready_o) got = 1;
      end
      if (!got) fail_now("reach_wr_resp");
      #3 reset_n = 0;
      #1 chk("async_reset_outputs_zero", outs_zero(), 1'b1);
      repeat (2) @(posedge clk);
      #1 reset_n = 1; b_mute = 0;
      repeat (2) @(posedge clk);
      #1 chk("idle_after_reset", cmd_ready_o, 1'b1);
      chk("no_rsp_after_reset", rsp_valid_o, 1'b0);
      do_cmd(0, 32'h3005, 32'h0, 4'h4, 2'b00, 32'hDEADBEEF, 1'b0, 0);
`ifdef AXIL_MST_TIMEOUT_EN
      b_mute = 1;
      do_cmd(1, 32'h3040, 32'h0000_0077, 4'hA, 2'b11, 32'h0, 1'b1, 0);
      chk("timeout_latency", (rsp_first_time - hs_time) / 10, TO + 1);
      b_mute = 0;
      repeat (5) @(posedge clk);
      #1 chk("stray_b_absorbed", bvalid, 1'b0);
      do_cmd(0, 32'h3005, 32'h0, 4'hB, 2'b00, 32'hDEADBEEF, 1'b0, 0);
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("exp_rsp_left", exp_rsp.size(), 0);
      chk("exp_aw_left", exp_aw.size(), 0);
      chk("exp_w_left", exp_w.size(), 0);
      chk("exp_ar_left", exp_ar.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
